// File: rtl/tx_msg_pkg.sv
// Shared definitions for the UART status-message scheduler.
//   - state_t       : scheduler FSM states
//   - MODE_*        : one-hot memory mode selects, bit order {START, INIT, NORMAL}
//   - priorityGrant : fixed-priority one-hot pick, START > INIT > NORMAL
package tx_msg_pkg;

  localparam int unsigned FRAME_LEN_DEFAULT = 35;

  localparam logic [2:0] MODE_START  = 3'b100;
  localparam logic [2:0] MODE_INIT   = 3'b010;
  localparam logic [2:0] MODE_NORMAL = 3'b001;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ADV,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_WRAP,
    ST_GAP
  } state_t;

  function automatic logic [2:0] priorityGrant(input logic [2:0] pend);
    logic [2:0] g;
    g = '0;
    if (pend[2])      g = MODE_START;
    else if (pend[1]) g = MODE_INIT;
    else if (pend[0]) g = MODE_NORMAL;
    return g;
  endfunction

endpackage

// File: rtl/tx_msg_if.sv
// Handshake bundle between the control side, the status-message memory
// and the UART transmitter.
//   master : request/UART-busy driver (control FSM + UART side)
//   slave  : the scheduler
interface tx_msg_if;

  logic       iREQ_START;
  logic       iREQ_INIT;
  logic       iREQ_NORMAL;
  logic       iUART_BUSY;
  logic       oTX_START_CONTROL;
  logic       oTX_INITIAL;
  logic       oTX_NORMAL;
  logic       oTX_ADVANCE;
  logic       oUART_START;
  logic       oBUSY;
  logic [5:0] oBYTE_CNT;
  logic       oFRAME_DONE;

  modport master (
    output iREQ_START, iREQ_INIT, iREQ_NORMAL, iUART_BUSY,
    input  oTX_START_CONTROL, oTX_INITIAL, oTX_NORMAL, oTX_ADVANCE,
           oUART_START, oBUSY, oBYTE_CNT, oFRAME_DONE
  );

  modport slave (
    input  iREQ_START, iREQ_INIT, iREQ_NORMAL, iUART_BUSY,
    output oTX_START_CONTROL, oTX_INITIAL, oTX_NORMAL, oTX_ADVANCE,
           oUART_START, oBUSY, oBYTE_CNT, oFRAME_DONE
  );

endinterface

// File: rtl/tx_msg_scheduler_arbiter.sv
// tx_req_arbiter: pending-request latch with fixed-priority grant.
//   clk, reset  : clock, asynchronous active-low reset
//   reqIn       : raw requests {START, INIT, NORMAL}, pulse or level
//   repeatSet   : auto-repeat set bits from the scheduler
//   activeMask  : type of the frame in flight; its requests are merged
//   clearMask   : bits cleared on entry to SELECT
//   pending     : latched request bits
//   grant       : one-hot winner among pending bits
//   anyPending  : OR of pending bits
module tx_req_arbiter
  import tx_msg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] reqIn,
  input  logic [2:0] repeatSet,
  input  logic [2:0] activeMask,
  input  logic [2:0] clearMask,
  output logic [2:0] pending,
  output logic [2:0] grant,
  output logic       anyPending
);

  // Clear wins over set so a request coinciding with SELECT entry is merged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending | (reqIn & ~activeMask) | repeatSet) & ~clearMask;
  end

  always_comb begin
    grant      = priorityGrant(pending);
    anyPending = |pending;
  end

endmodule

// File: rtl/tx_msg_scheduler.sv
// tx_msg_scheduler: sequences one status-message frame out of the message
// memory into the UART transmitter.
//   clk   : system clock
//   reset : asynchronous active-low reset (shared with the message memory)
//   bus   : tx_msg_if.slave -- requests, UART busy, mode selects, advance,
//           UART start, busy, byte index, frame-done pulse
// Optional feature: define TX_MSG_REPEAT_EN to re-send the last served
// message after REPEAT_CYCLES idle clocks.
module tx_msg_scheduler
  import tx_msg_pkg::*;
#(
  parameter int unsigned FRAME_LEN     = FRAME_LEN_DEFAULT,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned REPEAT_CYCLES = 50_000_000
) (
  input logic   clk,
  input logic   reset,
  tx_msg_if.slave bus
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  if (FRAME_LEN < 1 || FRAME_LEN > 64 || GAP_CYCLES < 1 || REPEAT_CYCLES < 1) begin : gParamCheck
    $error("tx_msg_scheduler: unsupported parameter value");
  end

  state_t          state, stateNext;
  logic [2:0]      mode;
  logic [5:0]      byteCnt;
  logic [GapW-1:0] gapCnt;
  logic            advance, uartStart, busyOut, frameDone;

  logic [2:0] pending, grant, repeatSet, clearMask;
  logic       anyPending, selEntry, lastByte;

  tx_req_arbiter uArb (
    .clk        (clk),
    .reset      (reset),
    .reqIn      ({bus.iREQ_START, bus.iREQ_INIT, bus.iREQ_NORMAL}),
    .repeatSet  (repeatSet),
    .activeMask (mode),
    .clearMask  (clearMask),
    .pending    (pending),
    .grant      (grant),
    .anyPending (anyPending)
  );

  assign selEntry  = (state == ST_IDLE) && anyPending;
  assign clearMask = selEntry ? grant : '0;
  assign lastByte  = (byteCnt == 6'(FRAME_LEN - 1));

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:      if (anyPending) stateNext = ST_SELECT;
      ST_SELECT:    stateNext = ST_ADV;
      ST_ADV:       stateNext = ST_LOAD;
      ST_LOAD:      stateNext = ST_SEND;
      ST_SEND:      stateNext = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (bus.iUART_BUSY) stateNext = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!bus.iUART_BUSY) stateNext = lastByte ? ST_WRAP : ST_ADV;
      ST_WRAP:      stateNext = ST_GAP;
      ST_GAP:       if (gapCnt == GapW'(GAP_CYCLES - 1)) stateNext = ST_IDLE;
      default:      stateNext = ST_IDLE;
    endcase
  end

  // Outputs are registered from stateNext so they appear in the same cycle
  // as the corresponding state, glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mode      <= '0;
      byteCnt   <= '0;
      gapCnt    <= '0;
      advance   <= 1'b0;
      uartStart <= 1'b0;
      busyOut   <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      state <= stateNext;

      if (selEntry)                                        mode <= grant;
      else if (stateNext == ST_GAP || stateNext == ST_IDLE) mode <= '0;

      if (selEntry)                                          byteCnt <= '0;
      else if (state == ST_WAIT_DONE && stateNext == ST_ADV) byteCnt <= byteCnt + 6'd1;

      if (state == ST_GAP) gapCnt <= gapCnt + 1'b1;
      else                 gapCnt <= '0;

      advance   <= (stateNext == ST_ADV) || (stateNext == ST_WRAP);
      uartStart <= (stateNext == ST_SEND);
      busyOut   <= (stateNext != ST_IDLE);
      frameDone <= (state == ST_WRAP);
    end
  end

`ifdef TX_MSG_REPEAT_EN
  localparam int unsigned RepeatW = $clog2(REPEAT_CYCLES + 1);

  logic [RepeatW-1:0] idleCnt;
  logic [2:0]         lastServed;
  logic               idleQuiet, repeatFire;

  assign idleQuiet  = (state == ST_IDLE) && !anyPending;
  assign repeatFire = idleQuiet && (idleCnt == RepeatW'(REPEAT_CYCLES - 1));
  // lastServed stays zero until the first frame, so no refresh is set before then.
  assign repeatSet  = repeatFire ? lastServed : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idleCnt    <= '0;
      lastServed <= '0;
    end else begin
      if (selEntry) lastServed <= grant;
      if (idleQuiet) idleCnt <= repeatFire ? '0 : idleCnt + 1'b1;
      else           idleCnt <= '0;
    end
  end
`else
  assign repeatSet = '0;
`endif

  assign bus.oTX_START_CONTROL = mode[2];
  assign bus.oTX_INITIAL       = mode[1];
  assign bus.oTX_NORMAL        = mode[0];
  assign bus.oTX_ADVANCE       = advance;
  assign bus.oUART_START       = uartStart;
  assign bus.oBUSY             = busyOut;
  assign bus.oBYTE_CNT         = byteCnt;
  assign bus.oFRAME_DONE       = frameDone;

endmodule

// File: tb/tb_tx_msg_scheduler.sv
// Directed bench for tx_msg_scheduler. The UART model holds iUART_BUSY for
// 9 cycles after each start pulse, giving 10 cycles of UART time per byte
// (WAIT_BUSY + WAIT_DONE), so one frame keeps oBUSY high 1+35*13+1+16 = 473.
module tb_tx_msg_scheduler;

  localparam int unsigned FRAME_LEN  = 35;
  localparam int unsigned GAP_CYCLES = 16;
  localparam int unsigned BUSY_LEN   = 9;
  localparam int unsigned FRAME_BUSY = 1 + FRAME_LEN * 13 + 1 + GAP_CYCLES;
  localparam int unsigned MODE_HIGH  = 1 + FRAME_LEN * 13 + 1;

  logic clk;
  logic reset;
  tx_msg_if bus ();

  tx_msg_scheduler #(
    .FRAME_LEN    (FRAME_LEN),
    .GAP_CYCLES   (GAP_CYCLES),
    .REPEAT_CYCLES(100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  int advCnt, startCnt, doneCnt, busyCycles, modeCycles, gapCycles;
  int onehotErr, switchErr;
  logic [2:0] prevMode;
  logic [2:0] modeQ[$];
  logic       stretchEn = 1'b0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART model
  initial begin
    int unsigned len;
    bus.iUART_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.oUART_START) begin
        len = (stretchEn && bus.oBYTE_CNT == 6'd5) ? 1000 : BUSY_LEN;
        @(posedge clk);
        #1 bus.iUART_BUSY = 1'b1;
        repeat (len) @(posedge clk);
        #1 bus.iUART_BUSY = 1'b0;
      end
    end
  end

  function automatic logic [2:0] curMode();
    return {bus.oTX_START_CONTROL, bus.oTX_INITIAL, bus.oTX_NORMAL};
  endfunction

  // Monitor
  initial begin
    prevMode = '0;
    forever begin
      @(negedge clk);
      if (bus.oTX_ADVANCE) advCnt++;
      if (bus.oUART_START) begin
        startCnt++;
        if (bus.oBYTE_CNT == 6'd0) modeQ.push_back(curMode());
      end
      if (bus.oFRAME_DONE) doneCnt++;
      if (bus.oBUSY) busyCycles++;
      if (curMode() != 3'b000) modeCycles++;
      if (bus.oBUSY && curMode() == 3'b000) gapCycles++;
      if ($countones(curMode()) > 1) onehotErr++;
      if (prevMode != 3'b000 && curMode() != 3'b000 && curMode() != prevMode) switchErr++;
      prevMode = curMode();
    end
  end

  task automatic clearStats();
    advCnt = 0; startCnt = 0; doneCnt = 0; busyCycles = 0;
    modeCycles = 0; gapCycles = 0; onehotErr = 0; switchErr = 0;
    modeQ.delete();
  endtask

  task automatic pulseReq(input logic [2:0] which);
    @(posedge clk);
    #1 {bus.iREQ_START, bus.iREQ_INIT, bus.iREQ_NORMAL} = which;
    @(posedge clk);
    #1 {bus.iREQ_START, bus.iREQ_INIT, bus.iREQ_NORMAL} = 3'b000;
  endtask

  // Wait for one frame (oBUSY rise then fall), bounded.
  task automatic waitFrame(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (!bus.oBUSY && n < maxCycles) begin @(negedge clk); n++; end
    while (bus.oBUSY && n < maxCycles) begin @(negedge clk); n++; end
    checkEq({tag, "_timeout"}, 32'(n >= maxCycles), 32'd0);
  endtask

  task automatic waitByte(input string tag, input logic [5:0] idx, input logic needBusy);
    int n;
    n = 0;
    while (!(bus.oBYTE_CNT == idx && bus.oBUSY && (!needBusy || bus.iUART_BUSY)) && n < 2000) begin
      @(negedge clk); n++;
    end
    checkEq({tag, "_timeout"}, 32'(n >= 2000), 32'd0);
  endtask

  function automatic logic [31:0] allOutputs();
    return {20'd0, bus.oTX_START_CONTROL, bus.oTX_INITIAL, bus.oTX_NORMAL, bus.oTX_ADVANCE,
            bus.oUART_START, bus.oBUSY, bus.oFRAME_DONE, 5'd0} | 32'(bus.oBYTE_CNT);
  endfunction

  initial begin
    int stuck;
    int advSnap, startSnap;
    clearStats();
    reset = 1'b0;
    {bus.iREQ_START, bus.iREQ_INIT, bus.iREQ_NORMAL} = 3'b000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkEq("reset_outputs", allOutputs(), 32'd0);

    // Single NORMAL request with cycle-exact start-up timing
    clearStats();
    @(posedge clk);
    #1 bus.iREQ_NORMAL = 1'b1;
    @(posedge clk);
    #1 bus.iREQ_NORMAL = 1'b0;
    checkEq("t_n_mode", 32'(bus.oTX_NORMAL), 32'd0);
    @(posedge clk); #1;
    checkEq("t_n1_mode", 32'(curMode()), 32'(3'b001));
    checkEq("t_n1_busy", 32'(bus.oBUSY), 32'd1);
    checkEq("t_n1_adv", 32'(bus.oTX_ADVANCE), 32'd0);
    @(posedge clk); #1;
    checkEq("t_n2_adv", 32'(bus.oTX_ADVANCE), 32'd1);
    @(posedge clk); #1;
    checkEq("t_n3_adv", 32'(bus.oTX_ADVANCE), 32'd0);
    checkEq("t_n3_start", 32'(bus.oUART_START), 32'd0);
    @(posedge clk); #1;
    checkEq("t_n4_start", 32'(bus.oUART_START), 32'd1);
    waitFrame("single", 3000);
    checkEq("single_starts", 32'(startCnt), 32'(FRAME_LEN));
    checkEq("single_advances", 32'(advCnt), 32'(FRAME_LEN + 1));
    checkEq("single_done", 32'(doneCnt), 32'd1);
    checkEq("single_busy_cycles", 32'(busyCycles), 32'(FRAME_BUSY));
    checkEq("single_mode_cycles", 32'(modeCycles), 32'(MODE_HIGH));
    checkEq("single_gap_cycles", 32'(gapCycles), 32'(GAP_CYCLES));
    checkEq("single_frames", 32'(modeQ.size()), 32'd1);
    if (modeQ.size() > 0) checkEq("single_mode", 32'(modeQ[0]), 32'(3'b001));

    // Three simultaneous requests
    clearStats();
    pulseReq(3'b111);
    for (int i = 0; i < 3; i++) waitFrame("simul", 3000);
    checkEq("simul_frames", 32'(modeQ.size()), 32'd3);
    if (modeQ.size() == 3) begin
      checkEq("simul_first", 32'(modeQ[0]), 32'(3'b100));
      checkEq("simul_second", 32'(modeQ[1]), 32'(3'b010));
      checkEq("simul_third", 32'(modeQ[2]), 32'(3'b001));
    end
    checkEq("simul_starts", 32'(startCnt), 32'(3 * FRAME_LEN));
    checkEq("simul_advances", 32'(advCnt), 32'(3 * (FRAME_LEN + 1)));
    checkEq("simul_gaps", 32'(gapCycles), 32'(3 * GAP_CYCLES));
    checkEq("simul_onehot", 32'(onehotErr), 32'd0);
    checkEq("simul_switch", 32'(switchErr), 32'd0);

    // INIT re-request mid-frame is merged
    clearStats();
    pulseReq(3'b010);
    waitByte("merge_wait", 6'd20, 1'b0);
    pulseReq(3'b010);
    waitFrame("merge", 3000);
    repeat (60) @(negedge clk);
    checkEq("merge_done", 32'(doneCnt), 32'd1);
    checkEq("merge_starts", 32'(startCnt), 32'(FRAME_LEN));
    checkEq("merge_busy_cycles", 32'(busyCycles), 32'(FRAME_BUSY));

    // Reset asserted at byte 12, then a clean START frame
    clearStats();
    pulseReq(3'b001);
    waitByte("rst_wait", 6'd12, 1'b0);
    #2 reset = 1'b0;
    #1 checkEq("rst_outputs", allOutputs(), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    stuck = 0;
    while (bus.iUART_BUSY && stuck < 50) begin @(negedge clk); stuck++; end
    clearStats();
    pulseReq(3'b100);
    waitFrame("rst_frame", 3000);
    checkEq("rst_frames", 32'(modeQ.size()), 32'd1);
    if (modeQ.size() > 0) checkEq("rst_mode", 32'(modeQ[0]), 32'(3'b100));
    checkEq("rst_starts", 32'(startCnt), 32'(FRAME_LEN));
    checkEq("rst_advances", 32'(advCnt), 32'(FRAME_LEN + 1));

    // UART stalls 1000 cycles on byte 5
    clearStats();
    stretchEn = 1'b1;
    pulseReq(3'b001);
    waitByte("stall_wait", 6'd5, 1'b1);
    advSnap   = advCnt;
    startSnap = startCnt;
    stuck     = 0;
    repeat (990) begin
      @(negedge clk);
      if (bus.oBYTE_CNT != 6'd5) stuck++;
    end
    checkEq("stall_bytecnt", 32'(stuck), 32'd0);
    checkEq("stall_advances", 32'(advCnt), 32'(advSnap));
    checkEq("stall_starts", 32'(startCnt), 32'(startSnap));
    waitFrame("stall", 4000);
    stretchEn = 1'b0;
    checkEq("stall_total_starts", 32'(startCnt), 32'(FRAME_LEN));
    checkEq("stall_busy_cycles", 32'(busyCycles), 32'(FRAME_BUSY + 991));

`ifdef TX_MSG_REPEAT_EN
    clearStats();
    waitFrame("repeat", 400);
    checkEq("repeat_frames", 32'(modeQ.size()), 32'd1);
    if (modeQ.size() > 0) checkEq("repeat_mode", 32'(modeQ[0]), 32'(3'b001));
`else
    clearStats();
    repeat (150) @(negedge clk);
    checkEq("norepeat_busy", 32'(busyCycles), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_msg_scheduler.md
# tx_msg_scheduler

Sequencer for the UART status-message memory. Latches message requests from the control FSM (start-control, initial, normal) and arbitrates them by fixed priority. For the winning message it drives the memory's one-hot mode select and byte-advance edge, and handshakes each byte into the UART transmitter. A full 35-byte frame goes out, the memory counter is wrapped back to 0, and an inter-frame gap is enforced.

## Interface
Parameters:
- FRAME_LEN, 35, bytes per message frame; memory counter wraps on advance number FRAME_LEN+1
- GAP_CYCLES, 16, idle clocks between frames
- REPEAT_CYCLES, 50_000_000, idle clocks before auto-repeat (only with TX_MSG_REPEAT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- iREQ_START  in  1  request start-control message; 1-cycle pulse or level
- iREQ_INIT  in  1  request initial message
- iREQ_NORMAL  in  1  request normal message
- iUART_BUSY  in  1  UART transmitter busy level
- oTX_START_CONTROL  out  1  memory mode select, held for the whole frame
- oTX_INITIAL  out  1  memory mode select
- oTX_NORMAL  out  1  memory mode select
- oTX_ADVANCE  out  1  registered byte-advance to memory; high exactly 1 cycle per advance
- oUART_START  out  1  1-cycle pulse: memory byte valid, UART may load it
- oBUSY  out  1  high from SELECT through GAP
- oBYTE_CNT  out  6  index of byte being sent, 0..FRAME_LEN-1
- oFRAME_DONE  out  1  1-cycle pulse on entry to GAP

## Operation
- Reset: all outputs 0, pending bits cleared, state IDLE, last-served type = none.
- Pending latch: each request input sets its pending bit on any cycle it is high.
  - A request for the type currently being sent is merged into that frame; its bit is cleared on entry to SELECT.
  - Requests for other types stay pending.
- Priority: START > INIT > NORMAL, evaluated only in IDLE.
- FSM states:
  - IDLE: if any pending bit is set, go to SELECT.
  - SELECT: assert the winner's mode select (one-hot; the other two stay 0); clear its pending bit; oBYTE_CNT=0; go to ADV.
  - ADV: oTX_ADVANCE=1; go to LOAD.
  - LOAD: oTX_ADVANCE=0 (memory data settles); go to SEND.
  - SEND: oUART_START=1; go to WAIT_BUSY.
  - WAIT_BUSY: wait for iUART_BUSY=1, then go to WAIT_DONE.
  - WAIT_DONE: on iUART_BUSY=0, if oBYTE_CNT==FRAME_LEN-1 go to WRAP; else increment oBYTE_CNT and go to ADV.
  - WRAP: oTX_ADVANCE=1 with mode still held; this is advance number FRAME_LEN+1 and returns the memory counter to 0 with no byte sent. Go to GAP.
  - GAP: mode selects drop to 0; oFRAME_DONE pulses on entry; count GAP_CYCLES; go to IDLE.
- Mode select must never change between the first ADV and WRAP of a frame, so the memory never sees a mode switch mid-frame.
- Simultaneous requests: all are latched; they are served in priority order, one frame each, separated by GAP.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. The memory shares this reset, so its counter is also cleared.

## Timing
- A request sampled at edge N: mode select high from N+1, oTX_ADVANCE high in cycle N+2, oUART_START in cycle N+4.
- Per byte: ADV → LOAD → SEND is 3 cycles, plus the UART time.
- Byte k+1 ADV starts 1 cycle after iUART_BUSY falls for byte k.
- Frame = FRAME_LEN × (3 + UART time) + 1 (WRAP) + GAP_CYCLES + 1 (SELECT) cycles.
- oTX_ADVANCE pulses per frame: exactly FRAME_LEN+1.

## Configuration
- TX_MSG_REPEAT_EN defined:
  - An idle counter runs in IDLE when no bits are pending; it is cleared on leaving IDLE.
  - When it reaches REPEAT_CYCLES, the last-served type's pending bit is set, giving a periodic status refresh.
  - If no type has been served since reset, nothing is set.
- TX_MSG_REPEAT_EN undefined: no idle counter; frames are sent only on explicit requests.

## Structure
- Package tx_msg_pkg:
  - state enum
  - one-hot mode constants (MODE_START, MODE_INIT, MODE_NORMAL)
  - FRAME_LEN default
- Sub-module tx_req_arbiter: pending latch, merge/clear logic, and fixed-priority one-hot grant. Instantiated once; the FSM, byte counter, gap counter and repeat counter stay in the top module.

## Test plan
- Single iREQ_NORMAL pulse, UART model busy 10 cycles per byte → exactly 35 oUART_START pulses and 36 oTX_ADVANCE pulses. oTX_NORMAL is held throughout, oFRAME_DONE pulses once, and the frame lasts 35×13+1+16+1 cycles.
- iREQ_NORMAL, iREQ_INIT and iREQ_START in the same cycle → frames are sent in order START, INIT, NORMAL with a 16-cycle gap between them, and only one mode select is high at any time.
- iREQ_INIT asserted while an INIT frame is at byte 20 → merged; no second frame follows.
- reset asserted at byte 12 → all outputs 0 within the same cycle. A following iREQ_START produces a clean frame starting at oBYTE_CNT=0.
- iUART_BUSY held high for 1000 cycles on byte 5 → no further advance or start pulse until it falls; oBYTE_CNT stays at 5.
- With TX_MSG_REPEAT_EN and REPEAT_CYCLES=100 → after a NORMAL frame and 100 idle cycles, a second NORMAL frame starts with no request.
